// File: rtl/sevenseg_pkg.sv
// Shared definitions for the seven-segment multiplexer: segment codes (g..a, active-low),
// controller state type and the largest displayable value for a given digit count.
package sevenseg_pkg;

    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_CONV = 1'b1
    } state_t;

    // 10^ndig - 1: the largest value that fits on ndig decimal digits.
    function automatic longint max_display(input int ndig);
        longint r;
        r = 1;
        for (int i = 0; i < ndig; i++) begin
            r = r * 10;
        end
        return r - 1;
    endfunction

    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        case (d)
            4'd0:    return SEG_0;
            4'd1:    return SEG_1;
            4'd2:    return SEG_2;
            4'd3:    return SEG_3;
            4'd4:    return SEG_4;
            4'd5:    return SEG_5;
            4'd6:    return SEG_6;
            4'd7:    return SEG_7;
            4'd8:    return SEG_8;
            4'd9:    return SEG_9;
            default: return SEG_BLANK;
        endcase
    endfunction

endpackage

// File: rtl/bin2bcd_serial.sv
// Serial double-dabble converter: one input bit per cycle, MSB first, VAL_W cycles per value.
// done is high in the cycle whose closing edge performs the final step; bcd/ovf are valid then.
module bin2bcd_serial
    import sevenseg_pkg::*;
#(
    parameter int VAL_W = 20,
    parameter int NDIG  = 6
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [VAL_W-1:0]  din,
    output logic              done,
    output logic [4*NDIG-1:0] bcd,
    output logic              ovf
);

    // Enough digits for any VAL_W-bit value, plus one guard digit above the visible ones.
    localparam int     CONV_DIG     = VAL_W / 3 + 1;
    localparam int     BCD_N        = ((CONV_DIG > NDIG) ? CONV_DIG : NDIG) + 1;
    localparam int     BCD_W        = 4 * BCD_N;
    localparam int     CNT_W        = $clog2(VAL_W);
    localparam longint VAL_MAX      = (longint'(1) << VAL_W) - 1;
    localparam bit     OVF_POSSIBLE = VAL_MAX > max_display(NDIG);

    logic [VAL_W-1:0] sr_q, sr_d;
    logic [BCD_W-1:0] bcd_q, bcd_d, adj;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             active_q, active_d;

    always_comb begin
        adj = bcd_q;
        for (int i = 0; i < BCD_N; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) begin
                adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
            end
        end
    end

    assign done = active_q && (cnt_q == CNT_W'(VAL_W - 1));

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        sr_d     = sr_q;
        bcd_d    = bcd_q;
        cnt_d    = cnt_q;
        active_d = active_q;
        if (start) begin
            sr_d     = din;
            bcd_d    = '0;
            cnt_d    = '0;
            active_d = 1'b1;
        end else if (active_q) begin
            bcd_d = {adj[BCD_W-2:0], sr_q[VAL_W-1]};
            sr_d  = {sr_q[VAL_W-2:0], 1'b0};
            cnt_d = cnt_q + 1'b1;
            if (done) begin
                active_d = 1'b0;
            end
        end
    end

    assign bcd = bcd_d[4*NDIG-1:0];
    // Any nonzero digit above the visible ones, or a bit shifted out of the guard digit.
    assign ovf = OVF_POSSIBLE && (|{adj[BCD_W-1], bcd_d[BCD_W-1:4*NDIG]});

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk) begin
        if (!reset) begin
            active_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            active_q <= active_d;
            cnt_q    <= cnt_d;
        end
    end

    // NOTE: the shift datapath is deliberately not reset; start loads it and it is only read on done.
    always_ff @(posedge clk) begin
        sr_q  <= sr_d;
        bcd_q <= bcd_d;
    end

endmodule

// File: rtl/sevenseg_mux.sv
// Multiplexed seven-segment driver: load a binary value, convert it to BCD in the
// background, and scan the held result across NDIG active-low digits.
module sevenseg_mux
    import sevenseg_pkg::*;
#(
    parameter int NDIG        = 6,
    parameter int VAL_W       = 20,
    parameter int REFRESH_DIV = 50000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [VAL_W-1:0] value,
    input  logic             load,
    input  logic             lz_blank,
    output logic             busy,
    output logic [6:0]       disp,
    output logic [NDIG-1:0]  dig
);

    localparam int PRE_W = $clog2(REFRESH_DIV);
    localparam int IDX_W = $clog2(NDIG);

    state_t            state_q, state_d;
    logic              start;
    logic              eng_done, eng_ovf;
    logic [4*NDIG-1:0] eng_bcd;
    logic [4*NDIG-1:0] val_q, val_d;
    logic              ovf_q, ovf_d;
    logic [PRE_W-1:0]  pre_q, pre_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [NDIG-1:0]   dig_q, dig_d;
    logic [6:0]        disp_q, disp_d;
    logic [3:0]        scan_digit;
    logic              scan_blank, lead_zero;

    bin2bcd_serial #(
        .VAL_W (VAL_W),
        .NDIG  (NDIG)
    ) u_conv (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .din   (value),
        .done  (eng_done),
        .bcd   (eng_bcd),
        .ovf   (eng_ovf)
    );

    // The display register changes only on completion, so the old result stays up during CONV.
    always_comb begin
        state_d = state_q;
        start   = 1'b0;
        val_d   = val_q;
        ovf_d   = ovf_q;
        case (state_q)
            ST_IDLE: begin
                if (load) begin
                    start   = 1'b1;
                    state_d = ST_CONV;
                end
            end
            ST_CONV: begin
                if (eng_done) begin
                    state_d = ST_IDLE;
                    val_d   = eng_bcd;
                    ovf_d   = eng_ovf;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        pre_d = pre_q + 1'b1;
        idx_d = idx_q;
        if (pre_q == PRE_W'(REFRESH_DIV - 1)) begin
            pre_d = '0;
            idx_d = (idx_q == IDX_W'(NDIG - 1)) ? '0 : idx_q + 1'b1;
        end
    end

    // Walk from the top digit down so lead_zero means "this digit and all above are zero".
    always_comb begin
        scan_digit = '0;
        scan_blank = 1'b0;
        lead_zero  = 1'b1;
        for (int i = NDIG - 1; i >= 0; i--) begin
            lead_zero = lead_zero && (val_q[4*i +: 4] == 4'd0);
            if (idx_q == IDX_W'(i)) begin
                scan_digit = val_q[4*i +: 4];
                scan_blank = lz_blank && lead_zero && (i != 0);
            end
        end
        if (ovf_q) begin
            disp_d = SEG_DASH;
        end else if (scan_blank) begin
            disp_d = SEG_BLANK;
        end else begin
            disp_d = seg_decode(scan_digit);
        end
        dig_d = ~(NDIG'(1) << idx_q);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            val_q   <= '0;
            ovf_q   <= 1'b0;
            pre_q   <= '0;
            idx_q   <= '0;
            dig_q   <= '1;
            disp_q  <= SEG_BLANK;
        end else begin
            state_q <= state_d;
            val_q   <= val_d;
            ovf_q   <= ovf_d;
            pre_q   <= pre_d;
            idx_q   <= idx_d;
            dig_q   <= dig_d;
            disp_q  <= disp_d;
        end
    end

    assign busy = (state_q == ST_CONV);
    assign disp = disp_q;
    assign dig  = dig_q;

endmodule

// File: tb/tb_sevenseg_mux.sv
// Scoreboard bench: stimulus pushes the values it expects to be displayed; a negedge
// monitor models scan timing and decimal rendering arithmetically and checks every cycle.
module tb_sevenseg_mux;

    localparam int NDIG        = 6;
    localparam int VAL_W       = 20;
    localparam int REFRESH_DIV = 4;

    logic             clk = 1'b0;
    logic             reset;
    logic [VAL_W-1:0] value;
    logic             load;
    logic             lz_blank;
    logic             busy;
    logic [6:0]       disp;
    logic [NDIG-1:0]  dig;

    int pass_cnt  = 0;
    int total_cnt = 0;
    int edge_no   = 0;
    int last_acc  = -1000;
    int exp_q[$];

    logic [6:0] seg_tab [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                                 7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};

    sevenseg_mux #(
        .NDIG        (NDIG),
        .VAL_W       (VAL_W),
        .REFRESH_DIV (REFRESH_DIV)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .value    (value),
        .load     (load),
        .lz_blank (lz_blank),
        .busy     (busy),
        .disp     (disp),
        .dig      (dig)
    );

    always #5 clk = ~clk;
    always @(posedge clk) edge_no++;

    task automatic check(input string name, input longint act, input longint exp);
        total_cnt++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    endtask

    function automatic int pow10(input int n);
        int r = 1;
        for (int i = 0; i < n; i++) r = r * 10;
        return r;
    endfunction

    // What digit position pos must show for value v, straight from decimal arithmetic.
    function automatic logic [6:0] model_seg(input int v, input logic lz, input int pos);
        int p = pow10(pos);
        if (v > pow10(NDIG) - 1) return 7'b0111111;
        if (lz && pos != 0 && v < p) return 7'b1111111;
        return seg_tab[(v / p) % 10];
    endfunction

    // Called at posedge+#1; the load is sampled at the next edge.
    task automatic do_load(input int v);
        int e;
        value = VAL_W'(v);
        load  = 1'b1;
        e     = edge_no + 1;
        if (e - last_acc >= VAL_W + 1) begin
            exp_q.push_back(v);
            last_acc = e;
        end
        @(posedge clk); #1;
        load = 1'b0;
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) begin
            @(posedge clk);
        end
        #1;
    endtask

    task automatic do_reset(input int n);
        reset = 1'b0;
        wait_cycles(n);
        reset    = 1'b1;
        last_acc = -1000;
    endtask

    // Monitor: inputs seen at the previous negedge are the ones the last edge sampled.
    logic p_rst_n = 1'b0;
    logic p_lz    = 1'b0;
    logic p_busy  = 1'b0;
    bit   armed   = 1'b0;
    int   mcnt    = 0;
    int   reg_val = 0;
    int   busy_run = 0;

    always @(negedge clk) begin
        int             exp_idx;
        logic [NDIG-1:0] exp_dig;
        if (!p_rst_n) begin
            armed = 1'b1;
            check("reset_dig", dig, {NDIG{1'b1}});
            check("reset_disp", disp, 7'b1111111);
            check("reset_busy", busy, 0);
            reg_val  = 0;
            mcnt     = 0;
            busy_run = 0;
            exp_q.delete();
        end else if (armed) begin
            exp_idx = (mcnt / REFRESH_DIV) % NDIG;
            mcnt++;
            exp_dig = ~(NDIG'(1) << exp_idx);
            check("scan_dig", dig, exp_dig);
            check("scan_disp", disp, model_seg(reg_val, p_lz, exp_idx));
            if (busy) begin
                busy_run++;
            end else if (p_busy) begin
                check("busy_len", busy_run, VAL_W);
                busy_run = 0;
                if (exp_q.size() == 0) check("unexpected_result", 0, 1);
                else reg_val = exp_q.pop_front();
            end
        end
        p_rst_n = reset;
        p_lz    = lz_blank;
        p_busy  = busy;
    end

    initial begin
        int v;
        reset    = 1'b0;
        load     = 1'b0;
        value    = '0;
        lz_blank = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        wait_cycles(30);

        do_load(123456);
        wait_cycles(50);

        lz_blank = 1'b1;
        do_load(42);
        wait_cycles(50);
        do_load(0);
        wait_cycles(50);

        lz_blank = 1'b0;
        do_load(1000000);
        wait_cycles(50);
        do_load(999999);
        wait_cycles(50);
        do_load(7);
        wait_cycles(50);

        // Loads during CONV and at the completion edge are dropped; the next edge accepts.
        do_load(555555);
        wait_cycles(4);
        do_load(111111);
        wait_cycles(14);
        do_load(222222);
        do_load(333333);
        wait_cycles(50);

        // Reset in the middle of a conversion.
        do_load(98765);
        wait_cycles(9);
        do_reset(1);
        wait_cycles(30);

        for (int i = 0; i < 10; i++) begin
            case ($urandom_range(0, 3))
                0:       v = int'($urandom_range(0, 99));
                1:       v = int'($urandom_range(0, 999999));
                2:       v = int'($urandom_range(999990, (1 << VAL_W) - 1));
                default: v = int'($urandom_range(0, (1 << VAL_W) - 1));
            endcase
            lz_blank = 1'($urandom_range(0, 1));
            do_load(v);
            wait_cycles(30);
            lz_blank = 1'($urandom_range(0, 1));
            wait_cycles(20);
        end

        wait_cycles(10);
        check("queue_drained", exp_q.size(), 0);
        check("final_busy", busy, 0);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
